// File: rtl/roll_hist_pkg.sv
// Shared types and constants for the die-roll requester / histogram collector.
package roll_hist_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_SAMPLE,
      S_GAP,
      S_DONE
   } state_t;

   localparam int unsigned FACE_MIN    = 1;
   localparam int unsigned FACE_MAX    = 6;
   localparam int unsigned NUM_FACES   = 6;
   localparam int unsigned RNG_LATENCY = 2;

   // True when a returned roll is a legal die face.
   function automatic logic is_face(input logic [2:0] v);
      return (v >= 3'(FACE_MIN)) && (v <= 3'(FACE_MAX));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + W'(1);
   end

endmodule

// File: rtl/roll_histogram.sv
// Issues N_ROLLS roll requests to the die-roll generator and histograms the
// returned values, counting out-of-range results separately.
module roll_histogram
   import roll_hist_pkg::*;
#(
   parameter int unsigned N_ROLLS = 16,
   parameter int unsigned GAP     = 2,
   parameter int unsigned CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       i_start,
   output logic                       o_pulse,
   input  logic [2:0]                 i_rn,
   output logic                       o_busy,
   output logic                       o_done,
   output logic [NUM_FACES*CNT_W-1:0] o_hist,
   output logic [CNT_W-1:0]           o_err_cnt,
   output logic [2:0]                 o_last_rn
);

   localparam int unsigned ROLL_W   = $clog2(N_ROLLS + 1);
   localparam int unsigned GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

   state_t             state;
   state_t             next_state;
   logic [ROLL_W-1:0]  roll_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic               clr;
   logic               sample;

   // Next-state decode; clr marks an accepted start, sample marks the capture edge.
   always_comb begin
      next_state = state;
      clr        = 1'b0;
      sample     = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_start) begin
               next_state = S_REQ;
               clr        = 1'b1;
            end
         end
         S_REQ:  next_state = S_WAIT;
         S_WAIT: next_state = S_SAMPLE;
         S_SAMPLE: begin
            sample = 1'b1;
            if (roll_cnt == ROLL_W'(N_ROLLS - 1))
               next_state = S_DONE;
            else if (GAP > 0)
               next_state = S_GAP;
            else
               next_state = S_REQ;
         end
         S_GAP: begin
            if (gap_cnt == GAP_W'(GAP_LAST))
               next_state = S_REQ;
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Control outputs are registered from the next state so they align with it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         roll_cnt  <= '0;
         gap_cnt   <= '0;
         o_pulse   <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_last_rn <= 3'b001;
      end else begin
         state   <= next_state;
         o_pulse <= (next_state == S_REQ);
         o_busy  <= (next_state != S_IDLE);
         o_done  <= (next_state == S_DONE);
         if (clr)
            roll_cnt <= '0;
         else if (sample)
            roll_cnt <= roll_cnt + ROLL_W'(1);
         if ((state == S_GAP) && (next_state == S_GAP))
            gap_cnt <= gap_cnt + GAP_W'(1);
         else
            gap_cnt <= '0;
         if (sample)
            o_last_rn <= i_rn;
      end
   end

   for (genvar k = 0; k < NUM_FACES; k++) begin : g_face
      sat_counter #(.W(CNT_W)) u_face (
         .clk   (clk),
         .rstn  (rstn),
         .clr   (clr),
         .inc   (sample && (i_rn == 3'(k + 1))),
         .count (o_hist[k*CNT_W +: CNT_W])
      );
   end

   sat_counter #(.W(CNT_W)) u_err (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (clr),
      .inc   (sample && !is_face(i_rn)),
      .count (o_err_cnt)
   );

endmodule
